barrier_map_builder: RTL

Upstream sequencer for the combinational barrier test (hor/vert in, in_barrier out). On start it rasters every lattice cell once, drives the cell coordinates to the barrier test, and samples the returned bit. It packs the bits into WORD_W-bit words and writes them into the barrier bitmap RAM through a valid/ready write port. The fluid update engine reads that bitmap for bounce-back.

---
 rtl/barrier_pkg.sv | 26 ++
 rtl/barrier_map_builder_bit_packer.sv | 47 ++++
 rtl/barrier_map_builder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/barrier_pkg.sv
// Shared types and sizing helpers for the barrier bitmap builder.
package barrier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int DEFAULT_WORD_W = 16;

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int safe_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int word_count(input int h, input int v, input int w);
        return (h * v) / w;
    endfunction

    function automatic int addr_width(input int h, input int v, input int w);
        return safe_width(word_count(h, v, w));
    endfunction

endpackage

// File: rtl/barrier_map_builder_bit_packer.sv
// Serial-to-parallel packer: collects one barrier bit per advance into a WORD_W word.
module bit_packer
    import barrier_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear,
    input  logic              advance,
    input  logic              bit_in,
    output logic              word_full,
    output logic [WORD_W-1:0] word
);

    localparam int IDX_W = safe_width(WORD_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] pack;

    // The completed word must already contain the bit arriving this cycle.
    always_comb begin
        word          = pack;
        word[bit_idx] = bit_in;
    end

    assign word_full = advance && (bit_idx == IDX_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bit_idx <= '0;
            pack    <= '0;
        end else if (clear) begin
            bit_idx <= '0;
            pack    <= '0;
        end else if (advance) begin
            pack[bit_idx] <= bit_in;
            if (word_full) begin
                bit_idx <= '0;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/barrier_map_builder.sv
// Rasters the lattice through the barrier test and writes the packed bitmap to RAM.
// Optional BARRIER_COUNT_EN adds barrier_count_out (number of barrier cells in the scan).
//
//  state | meaning
//  IDLE  | waiting for start_in
//  SCAN  | one cell per advance cycle, words pushed to the write port
//  DRAIN | last word waiting for acceptance
//  DONE  | one-cycle done_out pulse
module barrier_map_builder
    import barrier_pkg::*;
#(
    parameter int HPIXELS = 240,
    parameter int VPIXELS = 160,
    parameter int WORD_W  = DEFAULT_WORD_W
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          start_in,
    output logic [safe_width(HPIXELS)-1:0]                hor_out,
    output logic [safe_width(VPIXELS)-1:0]                vert_out,
    input  logic                                          in_barrier_in,
    output logic [addr_width(HPIXELS, VPIXELS, WORD_W)-1:0] wr_addr_out,
    output logic [WORD_W-1:0]                             wr_data_out,
    output logic                                          wr_valid_out,
    input  logic                                          wr_ready_in,
    output logic                                          busy_out,
    output logic                                          done_out
`ifdef BARRIER_COUNT_EN
    ,
    output logic [safe_width(HPIXELS*VPIXELS+1)-1:0]      barrier_count_out
`endif
);

    localparam int H_W = safe_width(HPIXELS);
    localparam int V_W = safe_width(VPIXELS);
    localparam int A_W = addr_width(HPIXELS, VPIXELS, WORD_W);
    localparam logic [H_W-1:0] H_LAST = H_W'(HPIXELS - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(VPIXELS - 1);

    scan_state_t state;
    scan_state_t next_state;

    logic             advance;
    logic             accept;
    logic             scan_start;
    logic             scan_adv;
    logic             last_cell;
    logic             word_full;
    logic [WORD_W-1:0] packed_word;
    logic [A_W-1:0]   word_cnt;

    assign advance    = !wr_valid_out || wr_ready_in;
    assign accept     = wr_valid_out && wr_ready_in;
    assign scan_start = (state == IDLE) && start_in;
    assign scan_adv   = (state == SCAN) && advance;
    assign last_cell  = (hor_out == H_LAST) && (vert_out == V_LAST);

    bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (scan_start),
        .advance   (scan_adv),
        .bit_in    (in_barrier_in),
        .word_full (word_full),
        .word      (packed_word)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) next_state = SCAN;
            end
            SCAN: begin
                busy_out = 1'b1;
                if (scan_adv && last_cell) next_state = DRAIN;
            end
            DRAIN: begin
                busy_out = 1'b1;
                // Leave on the cycle the final word is taken, so DONE sees an idle port.
                if (advance) next_state = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hor_out      <= '0;
            vert_out     <= '0;
            wr_addr_out  <= '0;
            wr_data_out  <= '0;
            wr_valid_out <= 1'b0;
            word_cnt     <= '0;
        end else begin
            if (scan_start) begin
                hor_out  <= '0;
                vert_out <= '0;
                word_cnt <= '0;
            end

            // A new word may replace one being accepted in the same cycle.
            if (scan_adv && word_full) begin
                wr_data_out  <= packed_word;
                wr_addr_out  <= word_cnt;
                wr_valid_out <= 1'b1;
                word_cnt     <= word_cnt + 1'b1;
            end else if (accept) begin
                wr_valid_out <= 1'b0;
            end

            if (scan_adv && !last_cell) begin
                if (hor_out == H_LAST) begin
                    hor_out  <= '0;
                    vert_out <= vert_out + 1'b1;
                end else begin
                    hor_out <= hor_out + 1'b1;
                end
            end
        end
    end

`ifdef BARRIER_COUNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            barrier_count_out <= '0;
        end else if (scan_start) begin
            barrier_count_out <= '0;
        end else if (scan_adv && in_barrier_in) begin
            barrier_count_out <= barrier_count_out + 1'b1;
        end
    end
`endif

endmodule
